// File: rtl/instr_sequencer.sv
// instr_sequencer: program-memory sequencer for the SHMCP_4 core.
// A host loads a small instruction RAM while idle; in run mode each word is
// fetched, presented on cpu_instr with a one-cycle cpu_load strobe, then held
// for an EXEC_CYCLES-long cpu_state window. HALT_OP stops sequencing.
// Optional single-step mode is enabled by defining SEQ_STEP_EN.
module instr_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned EXEC_CYCLES = 4,
    parameter logic [7:0]  HALT_OP     = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          run,
`ifdef SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [7:0]    cpu_instr,
    output logic          cpu_load,
    output logic          cpu_state,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          wr_err
);

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

`ifdef SEQ_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALT, S_STEPW
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALT
    } state_t;
`endif

    state_t         state;
    logic [7:0]     ram [DEPTH];
    logic [7:0]     rd_data;
    logic [CW-1:0]  cnt;

    // Host writes land only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            ram[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM with registered core-facing and status outputs.
    // The load strobe and instruction are registered on the FETCH edge so
    // they are valid during the ISSUE cycle itself; a halt word never loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            cpu_instr <= '0;
            cpu_load  <= 1'b0;
            cpu_state <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            wr_err    <= 1'b0;
            rd_data   <= '0;
            cnt       <= '0;
        end else begin
            wr_err <= prog_we && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    rd_data <= ram[pc];
                    if (ram[pc] != HALT_OP) begin
                        cpu_instr <= ram[pc];
                        cpu_load  <= 1'b1;
                    end
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    cpu_load <= 1'b0;
                    if (rd_data == HALT_OP) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state     <= S_EXEC;
                        cpu_state <= 1'b1;
                        cnt       <= CW'(EXEC_CYCLES - 1);
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        pc        <= pc + 1'b1;
                        cpu_state <= 1'b0;
                        if (run) begin
`ifdef SEQ_STEP_EN
                            state <= S_STEPW;
`else
                            state <= S_FETCH;
`endif
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state  <= S_IDLE;
                        halted <= 1'b0;
                        pc     <= '0;
                    end
                end
`ifdef SEQ_STEP_EN
                S_STEPW: begin
                    if (!run) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (step) begin
                        state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    halted    <= 1'b0;
                    cpu_load  <= 1'b0;
                    cpu_state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer.
// Expected values are hand-computed for EXEC_CYCLES=4 (period 6 cycles).
module tb_instr_sequencer;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          run;
`ifdef SEQ_STEP_EN
    logic          step;
`endif
    logic [7:0]    cpu_instr;
    logic          cpu_load;
    logic          cpu_state;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          wr_err;

    int total = 0;
    int bad   = 0;

`ifdef SEQ_STEP_EN
    localparam int PERIOD = 7;
`else
    localparam int PERIOD = 6;
`endif

    instr_sequencer #(
        .DEPTH(16),
        .AW(AW),
        .EXEC_CYCLES(4),
        .HALT_OP(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .run(run),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .cpu_instr(cpu_instr),
        .cpu_load(cpu_load),
        .cpu_state(cpu_state),
        .pc(pc),
        .busy(busy),
        .halted(halted),
        .wr_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ram(input logic [AW-1:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Advance until cpu_load is seen; n is the number of cycles waited.
    task automatic wait_load(output logic [7:0] v, output logic [AW-1:0] p, output int n);
        n = 0;
        v = '0;
        p = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (cpu_load) begin
                v = cpu_instr;
                p = pc;
                return;
            end
        end
        check("load_timeout", 32'd0, 32'd1);
    endtask

    // Advance until busy drops; returns the number of loads seen meanwhile.
    task automatic wait_idle(output int loads);
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_load) loads++;
            if (!busy) return;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    // The core must never see load and execute together.
    always @(negedge clk) begin
        check("load_state_excl", 32'(cpu_load & cpu_state), 32'd0);
    end

    logic [7:0]    v;
    logic [AW-1:0] p;
    int            n;
    int            loads;

    initial begin
        rst = 1'b0; run = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        // Reset held with run high
        repeat (3) tick();
        check("rst_instr",  32'(cpu_instr), 32'd0);
        check("rst_load",   32'(cpu_load),  32'd0);
        check("rst_state",  32'(cpu_state), 32'd0);
        check("rst_pc",     32'(pc),        32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_wr_err", 32'(wr_err),    32'd0);
        rst = 1'b1;
        tick();
        check("rel_fetch_busy", 32'(busy), 32'd1);
        rst = 1'b0; run = 1'b0;
        #1;
        check("rerst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Program with halt, then run
        write_ram(4'd0, 8'h12);
        write_ram(4'd1, 8'h34);
        write_ram(4'd2, 8'hFF);
        write_ram(4'd3, 8'h77);
        run = 1'b1;
        wait_load(v, p, n);
        check("i0_instr", 32'(v), 32'h12);
        check("i0_pc",    32'(p), 32'd0);
        wait_load(v, p, n);
        check("i1_instr",  32'(v), 32'h34);
        check("i1_pc",     32'(p), 32'd1);
        check("i1_period", 32'(n), 32'(PERIOD));
        loads = 0;
        for (int i = 0; i < 20 && !halted; i++) begin
            tick();
            if (cpu_load) loads++;
        end
        check("halt_flag",  32'(halted), 32'd1);
        check("halt_pc",    32'(pc),     32'd2);
        check("halt_busy",  32'(busy),   32'd0);
        check("halt_loads", 32'(loads),  32'd0);
        repeat (2) tick();
        check("halt_stays", 32'(halted), 32'd1);

        // Leave HALT, patch halt word, stop during EXEC of pc=1
        run = 1'b0;
        tick();
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_pc",   32'(pc),     32'd0);
        check("unhalt_busy", 32'(busy),   32'd0);
        write_ram(4'd2, 8'h56);
        run = 1'b1;
        wait_load(v, p, n);
        check("r0_instr", 32'(v), 32'h12);
        wait_load(v, p, n);
        check("r1_instr", 32'(v), 32'h34);
        tick();
        check("r1_exec", 32'(cpu_state), 32'd1);
        run = 1'b0;
        wait_idle(loads);
        check("stop_pc",    32'(pc),        32'd2);
        check("stop_loads", 32'(loads),     32'd0);
        check("stop_state", 32'(cpu_state), 32'd0);
        run = 1'b1;
        wait_load(v, p, n);
        check("resume_instr", 32'(v), 32'h56);
        check("resume_pc",    32'(p), 32'd2);

        // Write attempt during EXEC is dropped with a one-cycle error
        tick();
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'hAA;
        tick();
        prog_we = 1'b0;
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_clear", 32'(wr_err), 32'd0);
        wait_load(v, p, n);
        check("ram3_kept", 32'(v), 32'h77);
        check("ram3_pc",   32'(p), 32'd3);

        // Asynchronous reset mid-EXEC
        tick();
        tick();
        check("pre_rst_exec", 32'(cpu_state), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_state", 32'(cpu_state), 32'd0);
        check("arst_load",  32'(cpu_load),  32'd0);
        check("arst_pc",    32'(pc),        32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Full 16-word program wraps pc back to 0
        for (int i = 0; i < 16; i++) write_ram(AW'(i), 8'(8'h10 + i));
        run = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wait_load(v, p, n);
            check($sformatf("wrap_instr%0d", i), 32'(v), 32'(8'h10 + (i % 16)));
            check($sformatf("wrap_pc%0d", i),    32'(p), 32'(i % 16));
        end
        run = 1'b0;
        wait_idle(loads);
        check("wrap_stop_pc", 32'(pc), 32'd1);

`ifdef SEQ_STEP_EN
        // Single-step parking
        rst = 1'b0;
        tick();
        rst = 1'b1;
        step = 1'b0;
        write_ram(4'd0, 8'h21);
        write_ram(4'd1, 8'h22);
        write_ram(4'd2, 8'h23);
        run = 1'b1;
        wait_load(v, p, n);
        check("step_i0", 32'(v), 32'h21);
        for (int k = 0; k < 2; k++) begin
            loads = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (cpu_load) loads++;
            end
            check("stepw_loads", 32'(loads), 32'd0);
            check("stepw_busy",  32'(busy),  32'd1);
            step = 1'b1;
            tick();
            step = 1'b0;
            wait_load(v, p, n);
            check("step_instr", 32'(v), 32'(8'h22 + k));
        end
        run = 1'b0;
        wait_idle(loads);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
